// File: rtl/ara_pkg.sv
// Shared types for the permutation LUT unit: element and length types,
// the permutation command and the unit's FSM states.
package ara_pkg;

  localparam int unsigned ELEN     = 64;
  localparam int unsigned ARA_VLEN = 1024;

  typedef logic [ELEN-1:0]                elen_t;
  typedef logic [$clog2(ARA_VLEN+1)-1:0]  vlen_t;

  typedef struct packed {
    vlen_t      elem_count;
    logic [2:0] id;
  } permu_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_LUT = 2'd1,
    LOOKUP   = 2'd2
  } permu_lut_state_e;

endpackage

// File: rtl/permu_lut_unit.sv
// 16-entry byte LUT permutation: the first operand beat loads the table, later
// beats are translated byte-wise through it into a single-entry output register.
module permu_lut_unit
  import ara_pkg::*;
#(
  parameter int unsigned NrVRFBanksPerLane = 2,
  parameter int unsigned VLEN              = ara_pkg::ARA_VLEN,
  parameter type         permu_cmd_t       = ara_pkg::permu_cmd_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  permu_cmd_t                           cmd_i,
  input  logic                                 cmd_valid_i,
  output logic                                 cmd_ready_o,
  input  elen_t [NrVRFBanksPerLane-1:0]        operand_i,
  input  logic  [NrVRFBanksPerLane-1:0]        operand_valid_i,
  output logic                                 operand_ready_o,
  output elen_t [NrVRFBanksPerLane-1:0]        result_o,
  output logic  [8*NrVRFBanksPerLane-1:0]      result_be_o,
  output logic                                 result_valid_o,
  input  logic                                 result_ready_i,
  output logic                                 done_o,
  output logic  [2:0]                          done_id_o
);

  localparam int unsigned BeatBytes = 8 * NrVRFBanksPerLane;
  localparam int unsigned VW        = $clog2(VLEN + 1);

  typedef logic [VW-1:0]             vlen_t;
  typedef logic [VW:0]               vlen_ext_t;
  typedef logic [BeatBytes-1:0][7:0] beat_bytes_t;
  typedef logic [15:0][7:0]          lut_t;

  function automatic logic [7:0] lut_lookup(input lut_t lut, input logic [3:0] idx);
    return lut[idx];
  endfunction

  permu_lut_state_e state_q, state_d;
  vlen_t            elem_cnt_q, elem_cnt_d;
  vlen_t            byte_cnt_q, byte_cnt_d;
  logic [2:0]       id_q, id_d;
  lut_t             lut_q, lut_d;

  beat_bytes_t      result_q, result_d;
  logic [BeatBytes-1:0] result_be_q, result_be_d;
  logic             result_valid_q;
  logic             result_last_q;
  logic [2:0]       result_id_q;

  logic             done_q;
  logic [2:0]       done_id_q;
  logic             zpend_q;
  logic [2:0]       zpend_id_q;

  beat_bytes_t      in_bytes;
  logic             beat_push;
  logic             beat_last;
  logic             zero_done;
  logic             is_last;
  logic             result_hs;

  assign in_bytes  = operand_i;
  assign result_hs = result_valid_q && result_ready_i;

  // Extra MSB keeps the end-of-command test exact even near VLEN.
  assign is_last = ({1'b0, byte_cnt_q} + vlen_ext_t'(BeatBytes)) >= {1'b0, elem_cnt_q};

  always_comb begin
    state_d         = state_q;
    elem_cnt_d      = elem_cnt_q;
    byte_cnt_d      = byte_cnt_q;
    id_d            = id_q;
    lut_d           = lut_q;
    cmd_ready_o     = 1'b0;
    operand_ready_o = 1'b0;
    beat_push       = 1'b0;
    beat_last       = 1'b0;
    zero_done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          elem_cnt_d = vlen_t'(cmd_i.elem_count);
          id_d       = cmd_i.id;
          byte_cnt_d = '0;
          state_d    = LOAD_LUT;
        end
      end
      LOAD_LUT: begin
        operand_ready_o = 1'b1;
        if (&operand_valid_i) begin
          lut_d = in_bytes[15:0];
          if (elem_cnt_q == '0) begin
            state_d   = IDLE;
            zero_done = 1'b1;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        operand_ready_o = !result_valid_q || result_ready_i;
        if (&operand_valid_i && operand_ready_o) begin
          beat_push = 1'b1;
          if (is_last) begin
            beat_last  = 1'b1;
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + vlen_t'(BeatBytes);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      beat_push  = 1'b0;
      zero_done  = 1'b0;
    end
  end

  // Byte-wise translation with tail masking against the remaining count.
  always_comb begin
    result_d    = '0;
    result_be_d = '0;
    for (int k = 0; k < BeatBytes; k++) begin
      if (({1'b0, byte_cnt_q} + vlen_ext_t'(k)) < {1'b0, elem_cnt_q}) begin
        result_d[k]    = lut_lookup(lut_q, in_bytes[k][3:0]);
        result_be_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      elem_cnt_q <= '0;
      byte_cnt_q <= '0;
      id_q       <= '0;
      lut_q      <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      id_q       <= id_d;
      lut_q      <= lut_d;
    end
  end

  // Output register carries its own id/last so a new command can start
  // while the previous command's final beat is still waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q       <= '0;
      result_be_q    <= '0;
      result_valid_q <= 1'b0;
      result_last_q  <= 1'b0;
      result_id_q    <= '0;
      done_q         <= 1'b0;
      done_id_q      <= '0;
      zpend_q        <= 1'b0;
      zpend_id_q     <= '0;
    end else if (flush_i) begin
      result_valid_q <= 1'b0;
      result_last_q  <= 1'b0;
      done_q         <= 1'b0;
      zpend_q        <= 1'b0;
    end else begin
      if (beat_push) begin
        result_q       <= result_d;
        result_be_q    <= result_be_d;
        result_valid_q <= 1'b1;
        result_last_q  <= beat_last;
        result_id_q    <= id_q;
      end else if (result_hs) begin
        result_valid_q <= 1'b0;
      end

      done_q <= 1'b0;
      if (result_hs && result_last_q) begin
        done_q    <= 1'b1;
        done_id_q <= result_id_q;
        if (zero_done) begin
          zpend_q    <= 1'b1;
          zpend_id_q <= id_q;
        end
      end else if (zero_done) begin
        done_q    <= 1'b1;
        done_id_q <= id_q;
      end else if (zpend_q) begin
        done_q    <= 1'b1;
        done_id_q <= zpend_id_q;
        zpend_q   <= 1'b0;
      end
    end
  end

  assign result_o       = result_q;
  assign result_be_o    = result_be_q;
  assign result_valid_o = result_valid_q;
  assign done_o         = done_q;
  assign done_id_o      = done_id_q;

endmodule

// File: tb/tb_permu_lut_unit.sv
// Self-checking bench for permu_lut_unit: directed scenarios plus randomized
// commands compared against a byte-level reference model.
module tb_permu_lut_unit;
  import ara_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  permu_cmd_t   cmd;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [127:0] op;
  logic [1:0]   op_v;
  logic         op_rdy;
  logic [127:0] res;
  logic [15:0]  be;
  logic         res_v;
  logic         res_rdy = 1'b0;
  logic         done;
  logic [2:0]   done_id;

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;
  int cyc = 0;

  logic [127:0] exp_data[$], obs_data[$];
  logic [15:0]  exp_be[$],   obs_be[$];
  logic [2:0]   exp_done[$], obs_done[$];
  int           hs_cyc[$],   done_cyc[$];

  permu_lut_unit #(
    .NrVRFBanksPerLane(2),
    .VLEN(1024),
    .permu_cmd_t(ara_pkg::permu_cmd_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .operand_i(op), .operand_valid_i(op_v), .operand_ready_o(op_rdy),
    .result_o(res), .result_be_o(be), .result_valid_o(res_v), .result_ready_i(res_rdy),
    .done_o(done), .done_id_o(done_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       res_rdy = 1'b0;
      1:       res_rdy = 1'b1;
      default: res_rdy = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_v === 1'b1 && res_rdy === 1'b1) begin
      obs_data.push_back(res); obs_be.push_back(be); hs_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      obs_done.push_back(done_id); done_cyc.push_back(cyc);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: every byte position below elem_count maps through the table.
  function automatic void model(input logic [127:0] lutb, input int elem,
                                input logic [2:0] id, input logic [127:0] beats[$]);
    logic [7:0]   lut[16];
    logic [127:0] d;
    logic [15:0]  m;
    for (int i = 0; i < 16; i++) lut[i] = lutb[8*i +: 8];
    for (int b = 0; b < beats.size(); b++) begin
      d = '0; m = '0;
      for (int k = 0; k < 16; k++)
        if (16*b + k < elem) begin
          d[8*k +: 8] = lut[beats[b][8*k +: 4]];
          m[k] = 1'b1;
        end
      exp_data.push_back(d); exp_be.push_back(m);
    end
    exp_done.push_back(id);
  endfunction

  task automatic clear_q();
    exp_data.delete(); exp_be.delete(); exp_done.delete();
    obs_data.delete(); obs_be.delete(); obs_done.delete();
    hs_cyc.delete(); done_cyc.delete();
  endtask

  task automatic set_ready(input int m);
    rdy_mode = m;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic start_cmd(input logic [2:0] id, input int elem);
    int t = 0;
    cmd.id = id; cmd.elem_count = vlen_t'(elem); cmd_valid = 1'b1;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) begin
      tests++; fails++;
      $display("FAIL cmd_timeout: cmd_ready got %b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input bit partial, output int waited);
    op = d;
    if (partial) begin
      op_v = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    op_v = 2'b11; waited = 0;
    @(negedge clk);
    while (op_rdy !== 1'b1 && waited < 500) begin @(negedge clk); waited++; end
    if (waited >= 500) begin
      tests++; fails++;
      $display("FAIL beat_timeout: operand_ready got %b, required 1", op_rdy);
    end
    @(posedge clk); #1;
    op_v = 2'b00;
  endtask

  task automatic run_cmd(input logic [2:0] id, input int elem, input logic [127:0] lutb, input bit partial);
    logic [127:0] beats[$];
    int w;
    for (int b = 0; b < (elem + 15) / 16; b++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
    model(lutb, elem, id, beats);
    start_cmd(id, elem);
    send_beat(lutb, partial, w);
    foreach (beats[b]) send_beat(beats[b], partial, w);
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (obs_done.size() < n && t < 2000) begin @(posedge clk); #1; t++; end
    repeat (4) begin @(posedge clk); #1; end
    if (t >= 2000) begin
      tests++; fails++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", obs_done.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; cmd = '0; cmd_valid = 1'b0; op = '0; op_v = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({res_v, done, done_id, res, be, cmd_ready, op_rdy} !== {1'b0, 1'b0, 3'd0, 128'd0, 16'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got v=%b d=%b id=%0d res=%h be=%h cr=%b or=%b, required 0/0/0/0/0/1/0",
               res_v, done, done_id, res, be, cmd_ready, op_rdy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    logic [127:0] lutb, d, e;
    int w;
    clear_q(); set_ready(1);
    for (int i = 0; i < 16; i++) begin
      lutb[8*i +: 8] = 8'(i);
      d[8*i +: 8]    = 8'h3A + 8'(i);
      e[8*i +: 8]    = (8'h3A + 8'(i)) & 8'h0F;
    end
    start_cmd(3'd2, 16);
    send_beat(lutb, 1'b0, w);
    send_beat(d, 1'b0, w);
    wait_done(1);
    tests++;
    if (obs_data.size() !== 1 || obs_data[0] !== e || obs_be[0] !== 16'hFFFF) begin
      fails++;
      $display("FAIL identity_data: got %0d beats first=%h be=%h, required 1 beat %h be=ffff",
               obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : '0, (obs_be.size() > 0) ? obs_be[0] : '0, e);
    end
    tests++;
    if (obs_done.size() !== 1 || obs_done[0] !== 3'd2) begin
      fails++;
      $display("FAIL identity_done: got %0d pulses id=%0d, required 1 pulse id=2",
               obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : 3'd0);
    end
  endtask

  task automatic test_tail();
    clear_q(); set_ready(1);
    run_cmd(3'd7, 20, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_done(1);
    tests++;
    if (obs_data.size() !== 2) begin
      fails++; $display("FAIL tail_count: got %0d beats, required 2", obs_data.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (obs_data[i] !== exp_data[i] || obs_be[i] !== exp_be[i]) begin
          fails++; $display("FAIL tail_beat%0d: got %h/%h, required %h/%h", i, obs_data[i], obs_be[i], exp_data[i], exp_be[i]);
        end
      end
      tests++;
      if (obs_be[1] !== 16'h000F || obs_data[1][127:32] !== '0) begin
        fails++; $display("FAIL tail_mask: got be=%h upper=%h, required be=000f upper=0", obs_be[1], obs_data[1][127:32]);
      end
      tests++;
      if (done_cyc.size() !== 1 || done_cyc[0] !== hs_cyc[1] + 1 || obs_done[0] !== 3'd7) begin
        fail_done_timing();
      end
    end
  endtask

  task automatic fail_done_timing();
    fails++;
    $display("FAIL tail_done: got %0d pulses at cycle %0d, required 1 pulse id=7 at cycle %0d",
             done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, hs_cyc[1] + 1);
  endtask

  task automatic test_zero();
    logic [127:0] lutb;
    int w;
    clear_q(); set_ready(1);
    lutb = {$urandom, $urandom, $urandom, $urandom};
    start_cmd(3'd3, 0);
    send_beat(lutb, 1'b0, w);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || done_id !== 3'd3 || res_v !== 1'b0) begin
      fails++; $display("FAIL zero_done: got done=%b id=%0d valid=%b, required 1/3/0", done, done_id, res_v);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || obs_data.size() !== 0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL zero_after: got done=%b beats=%0d cmd_ready=%b, required 0/0/1", done, obs_data.size(), cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_partial_valid();
    logic [127:0] lutb, d, e;
    int w;
    clear_q(); set_ready(1);
    for (int i = 0; i < 16; i++) begin
      lutb[8*i +: 8] = 8'(15 - i);
      d[8*i +: 8]    = 8'($urandom);
      e[8*i +: 8]    = 8'(15) - {4'd0, d[8*i +: 4]};
    end
    start_cmd(3'd1, 16);
    send_beat(lutb, 1'b0, w);
    op = d; op_v = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (res_v !== 1'b0) begin
        fails++; $display("FAIL partial_accept: cycle %0d result_valid got %b, required 0", c, res_v);
      end
    end
    @(posedge clk); #1;
    send_beat(d, 1'b0, w);
    wait_done(1);
    tests++;
    if (obs_data.size() !== 1 || obs_data[0] !== e) begin
      fails++; $display("FAIL partial_full: got %0d beats first=%h, required 1 beat %h",
                        obs_data.size(), (obs_data.size() > 0) ? obs_data[0] : '0, e);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] lutb, snap;
    logic [127:0] beats[$];
    int w;
    clear_q(); set_ready(0);
    lutb = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < 4; b++) beats.push_back({$urandom, $urandom, $urandom, $urandom});
    model(lutb, 64, 3'd5, beats);
    start_cmd(3'd5, 64);
    send_beat(lutb, 1'b0, w);
    send_beat(beats[0], 1'b0, w);
    op = beats[1]; op_v = 2'b11;
    @(negedge clk);
    snap = res;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (res !== snap || res_v !== 1'b1 || op_rdy !== 1'b0) begin
        fails++; $display("FAIL stall_hold: cycle %0d got res=%h v=%b ordy=%b, required %h/1/0", c, res, res_v, op_rdy, snap);
      end
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    send_beat(beats[1], 1'b0, w);
    for (int b = 2; b < 4; b++) begin
      send_beat(beats[b], 1'b0, w);
      tests++;
      if (w !== 0) begin
        fails++; $display("FAIL throughput: beat %0d waited %0d cycles, required 0", b, w);
      end
    end
    wait_done(1);
    tests++;
    if (obs_data.size() !== 4) begin
      fails++; $display("FAIL stall_count: got %0d beats, required 4", obs_data.size());
    end
    for (int i = 0; i < 4 && i < obs_data.size(); i++) begin
      tests++;
      if (obs_data[i] !== exp_data[i] || obs_be[i] !== exp_be[i]) begin
        fails++; $display("FAIL stall_beat%0d: got %h/%h, required %h/%h", i, obs_data[i], obs_be[i], exp_data[i], exp_be[i]);
      end
    end
    tests++;
    if (obs_done.size() !== 1 || obs_done[0] !== 3'd5) begin
      fails++; $display("FAIL stall_done: got %0d pulses, required 1 with id 5", obs_done.size());
    end
  endtask

  task automatic test_flush();
    int w;
    clear_q(); set_ready(0);
    start_cmd(3'd4, 64);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, w);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, w);
    op_v = 2'b11; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; op_v = 2'b00;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1 || res_v !== 1'b0 || op_rdy !== 1'b0) begin
      fails++; $display("FAIL flush_state: got cmd_ready=%b valid=%b ordy=%b, required 1/0/0", cmd_ready, res_v, op_rdy);
    end
    @(posedge clk); #1;
    set_ready(1);
    repeat (8) begin @(posedge clk); #1; end
    tests++;
    if (obs_done.size() !== 0 || obs_data.size() !== 0) begin
      fails++; $display("FAIL flush_nodone: got %0d dones %0d beats, required 0/0", obs_done.size(), obs_data.size());
    end
  endtask

  task automatic test_reset_midop();
    int w;
    clear_q(); set_ready(0);
    start_cmd(3'd6, 64);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, w);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, w);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({res_v, res, be, done_id, cmd_ready} !== {1'b0, 128'd0, 16'd0, 3'd0, 1'b1}) begin
      fails++; $display("FAIL midop_reset: got v=%b res=%h be=%h id=%0d cr=%b, required 0/0/0/0/1", res_v, res, be, done_id, cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_ready(1);
    repeat (8) begin @(posedge clk); #1; end
    tests++;
    if (obs_done.size() !== 0) begin
      fails++; $display("FAIL midop_nodone: got %0d done pulses, required 0", obs_done.size());
    end
  endtask

  task automatic test_random();
    clear_q(); set_ready(2);
    for (int i = 0; i < 24; i++)
      run_cmd(3'(i), $urandom_range(0, 72), {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2) == 0);
    wait_done(24);
    tests++;
    if (obs_data.size() !== exp_data.size() || obs_done.size() !== exp_done.size()) begin
      fails++; $display("FAIL rand_count: got %0d beats %0d dones, required %0d/%0d",
                        obs_data.size(), obs_done.size(), exp_data.size(), exp_done.size());
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      tests++;
      if (obs_data[i] !== exp_data[i] || obs_be[i] !== exp_be[i]) begin
        fails++; $display("FAIL rand_beat%0d: got %h/%h, required %h/%h", i, obs_data[i], obs_be[i], exp_data[i], exp_be[i]);
      end
    end
    for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++) begin
      tests++;
      if (obs_done[i] !== exp_done[i]) begin
        fails++; $display("FAIL rand_done%0d: got id %0d, required %0d", i, obs_done[i], exp_done[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_tail();
    test_zero();
    test_partial_valid();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/permu_lut_unit.md
PERMU_LUT_UNIT -- requirements
Module: permu_lut_unit

Interface
REQ-001 SHALL have parameter NrVRFBanksPerLane, default 2, meaning operand beat width in elen_t words; legal values are 2 or more.
REQ-002 SHALL have parameter VLEN, default 0, meaning vector length in bits; it sizes vlen_t as logic[$clog2(VLEN+1)-1:0].
REQ-003 SHALL have parameter permu_cmd_t, default logic, meaning the command type with fields elem_count (vlen_t, bytes to transform) and id (3 bits).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1 bit: synchronous abort of the current operation.
REQ-007 SHALL have ports cmd_i (input, permu_cmd_t), cmd_valid_i (input, 1 bit) and cmd_ready_o (output, 1 bit): the command handshake.
REQ-008 SHALL have ports operand_i (input, elen_t[NrVRFBanksPerLane]), operand_valid_i (input, NrVRFBanksPerLane bits) and operand_ready_o (output, 1 bit): beats from the permutation operand queue.
REQ-009 SHALL have ports result_o (output, elen_t[NrVRFBanksPerLane]), result_be_o (output, 8*NrVRFBanksPerLane bits), result_valid_o (output, 1 bit) and result_ready_i (input, 1 bit): results towards the VRF writeback.
REQ-010 SHALL have ports done_o (output, 1 bit) and done_id_o (output, 3 bits): single-cycle completion pulse and the id of the completed command.

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD_LUT and LOOKUP.
REQ-012 SHALL drive cmd_ready_o=1 only in IDLE; on a cmd handshake SHALL latch elem_count and id, clear the byte counter and go to LOAD_LUT.
REQ-013 SHALL define beat acceptance as &operand_valid_i && operand_ready_o.
REQ-014 SHALL accept partial-valid beats (not all banks valid) never; such beats SHALL wait.
REQ-015 In LOAD_LUT, operand_ready_o SHALL be 1.
REQ-016 On the first accepted beat in LOAD_LUT, bytes 0..15 of operand_i (bank 0 byte 0 first) SHALL be stored as LUT[0..15].
REQ-017 After the LUT load, the FSM SHALL go to LOOKUP; if elem_count==0 it SHALL instead return to IDLE and pulse done_o.
REQ-018 In LOOKUP, operand_ready_o SHALL be (!result_valid_o || result_ready_i).
REQ-019 In LOOKUP, each accepted beat SHALL produce, one cycle later on the registered result_o, output byte k = LUT[in_byte_k[3:0]].
REQ-020 result_be_o bit k SHALL be 1 iff byte_count+k < elem_count; masked bytes SHALL output 0.
REQ-021 Per accepted beat, the byte counter SHALL advance by BeatBytes = 8*NrVRFBanksPerLane.
REQ-022 The beat for which byte_count+BeatBytes >= elem_count SHALL be marked last; the FSM SHALL then return to IDLE (a new command may be accepted in the next cycle).
REQ-023 done_o SHALL pulse for one cycle on the result handshake of the last beat, with done_id_o equal to the latched id.
REQ-024 result_valid_o SHALL stay asserted, with result_o stable, until result_ready_i; simultaneous pop and push SHALL sustain 1 beat/cycle.
REQ-025 The byte counter SHALL be vlen_t and SHALL never wrap; comparisons SHALL use at least one extra bit.
REQ-026 flush_i SHALL force IDLE, clear result_valid_o, the counter and any pending done in the same edge; flush SHALL take priority over every other event.

Reset
REQ-027 On rst_ni low, state SHALL be IDLE, LUT and counter 0, result_valid_o=0, done_o=0, done_id_o=0, result_o=0, result_be_o=0.
REQ-028 Reset asserted mid-operation SHALL discard the command with no done pulse.

Structure
REQ-029 permu_cmd_t and the FSM state enum SHALL live in ara_pkg; BeatBytes SHALL be a localparam.
REQ-030 The single-entry output register SHALL be built inline; no sub-module is required, and the optional LUT byte lookup SHALL be a function, not a module.

Verification
REQ-031 Identity LUT (LUT[i]=i), elem_count=16, NrVRFBanksPerLane=2, input bytes 0x3A..: result_o bytes equal to the low nibbles, be=0xFFFF, one done with the matching id.
REQ-032 elem_count=20: two result beats, the second with be=0x000F, upper bytes 0, done only after the second handshake.
REQ-033 elem_count=0: LUT beat consumed, no result_valid_o, done_o pulses one cycle later.
REQ-034 result_ready_i held low for 5 cycles: result_o stable, operand_ready_o=0, no beat lost; throughput returns to 1/cycle.
REQ-035 flush_i mid-LOOKUP: next cycle IDLE, result_valid_o=0, cmd_ready_o=1, no done pulse.
REQ-036 operand_valid_i=2'b01 for 3 cycles: no acceptance; 2'b11 accepted.
